arrow_sprite_pipe: RTL and testbench

Pipelined, parametrised arrow sprite renderer for the game video path. It draws an arrowhead-plus-shaft shape at a frame-latched position in any of four orientations. It also implements a hit/flash/retire animation state machine clocked by frame pulses. It sits between the hcount/vcount generator and the pixel compositor, and replaces fixed-size, up-only, unregistered arrow drawing.

---
 rtl/arrow_pkg.sv | 36 +++
 rtl/arrow_shape_lut.sv | 93 +++++++++
 rtl/arrow_sprite_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_arrow_sprite_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
// Shared types and helpers for the arrow sprite renderer.
package arrow_pkg;

  typedef enum logic [1:0] {
    ROT_UP    = 2'd0,
    ROT_RIGHT = 2'd1,
    ROT_DOWN  = 2'd2,
    ROT_LEFT  = 2'd3
  } rot_t;

  typedef enum logic [1:0] {
    S_SHOW  = 2'd0,
    S_FLASH = 2'd1,
    S_DONE  = 2'd2
  } arrow_state_t;

  // Clocks from hcount/vcount to pixel_out/in_sprite.
  localparam int PIPE_LAT = 2;

  // Half-width of the arrowhead at row v (measured from the tip), never below 1.
  function automatic logic signed [11:0] head_half_width(input logic [7:0] v,
                                                         input int width,
                                                         input int head_h);
    int prod;
    int hw;
    prod = (int'(v) + 1) * width;
    hw   = prod / (2 * head_h);
    if (hw < 1) begin
      hw = 1;
    end else begin
      hw = hw;
    end
    return $signed(12'(hw));
  endfunction

endpackage

// File: rtl/arrow_shape_lut.sv
// Combinational shape evaluation: maps box-relative (dx, dy) and orientation
// to tip-relative (u, v) and decides box membership and arrow coverage.
module arrow_shape_lut
  import arrow_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int HEIGHT  = 32,
  parameter int HEAD_H  = 8,
  parameter int SHAFT_W = 8
) (
  input  logic [1:0]  rot_in,
  input  logic [11:0] dx_in,
  input  logic [11:0] dy_in,
  output logic        inbox_out,
  output logic        shape_out
);

  localparam logic signed [11:0] W_C        = 12'(WIDTH);
  localparam logic signed [11:0] H_C        = 12'(HEIGHT);
  localparam logic signed [11:0] HH_C       = 12'(HEAD_H);
  localparam logic signed [11:0] HALF_C     = 12'(WIDTH / 2);
  localparam logic signed [11:0] SHAFT_LO_C = 12'((WIDTH - SHAFT_W) / 2);
  localparam logic signed [11:0] SHAFT_HI_C = 12'((WIDTH + SHAFT_W) / 2);

  logic signed [11:0] dx_s;
  logic signed [11:0] dy_s;
  logic signed [11:0] box_w_s;
  logic signed [11:0] box_h_s;
  logic signed [11:0] u_s;
  logic signed [11:0] v_s;
  logic signed [11:0] hw_s;

  // Orientation transform: pick box extents and local (u across, v from tip).
  always_comb begin
    dx_s    = $signed(dx_in);
    dy_s    = $signed(dy_in);
    box_w_s = W_C;
    box_h_s = H_C;
    u_s     = dx_s;
    v_s     = dy_s;
    case (rot_t'(rot_in))
      ROT_UP: begin
        box_w_s = W_C;
        box_h_s = H_C;
        u_s     = dx_s;
        v_s     = dy_s;
      end
      ROT_RIGHT: begin
        box_w_s = H_C;
        box_h_s = W_C;
        u_s     = dy_s;
        v_s     = H_C - 12'sd1 - dx_s;
      end
      ROT_DOWN: begin
        box_w_s = W_C;
        box_h_s = H_C;
        u_s     = W_C - 12'sd1 - dx_s;
        v_s     = H_C - 12'sd1 - dy_s;
      end
      ROT_LEFT: begin
        box_w_s = H_C;
        box_h_s = W_C;
        u_s     = W_C - 12'sd1 - dy_s;
        v_s     = dx_s;
      end
      default: begin
        box_w_s = W_C;
        box_h_s = H_C;
        u_s     = dx_s;
        v_s     = dy_s;
      end
    endcase
  end

  // Box test on signed offsets, so negative offsets can never wrap into the box.
  always_comb begin
    inbox_out = (dx_s >= 12'sd0) && (dy_s >= 12'sd0) &&
                (dx_s < box_w_s) && (dy_s < box_h_s);
  end

  // Arrow coverage: widening triangular head, then a centred constant-width shaft.
  always_comb begin
    hw_s = 12'sd1;
    if (v_s < HH_C) begin
      hw_s      = head_half_width(v_s[7:0], WIDTH, HEAD_H);
      shape_out = (u_s >= (HALF_C - hw_s)) && (u_s < (HALF_C + hw_s));
    end else begin
      hw_s      = 12'sd1;
      shape_out = (u_s >= SHAFT_LO_C) && (u_s < SHAFT_HI_C);
    end
  end

endmodule

// File: rtl/arrow_sprite_pipe.sv
// Two-stage pipelined arrow sprite renderer with a hit/flash/retire animation.
// Optional build macro ARROW_BLINK_EN adds a 16-frame blink to target arrows
// while they are shown.
module arrow_sprite_pipe
  import arrow_pkg::*;
#(
  parameter int          WIDTH           = 16,
  parameter int          HEIGHT          = 32,
  parameter int          HEAD_H          = 8,
  parameter int          SHAFT_W         = 8,
  parameter logic [11:0] TARGET_COLOR    = 12'hF00,
  parameter logic [11:0] NONTARGET_COLOR = 12'hFF0,
  parameter logic [11:0] HIT_COLOR       = 12'hFFF,
  parameter int          FLASH_FRAMES    = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [1:0]  rotate_in,
  input  logic        next_in,
  input  logic        new_frame_in,
  input  logic        hit_in,
  input  logic        rearm_in,
  output logic [11:0] pixel_out,
  output logic        in_sprite,
  output logic        flashing_out,
  output logic        done_out
);

  localparam int               CNT_W    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

  // Frame-latched sprite attributes
  logic [10:0]  x_lat_q, x_lat_d;
  logic [9:0]   y_lat_q, y_lat_d;
  logic [1:0]   rot_lat_q, rot_lat_d;
  logic         next_lat_q, next_lat_d;
  // Stage 1
  logic [11:0]  dx_q, dx_d;
  logic [11:0]  dy_q, dy_d;
  logic [1:0]   rot_s1_q, rot_s1_d;
  // Stage 2 / outputs
  logic         in_sprite_q, in_sprite_d;
  logic [11:0]  pixel_q, pixel_d;
  logic         flashing_q, flashing_d;
  logic         done_q, done_d;
  // Animation
  arrow_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic         inbox_s;
  logic         shape_s;
  logic         blink_vis_s;
  logic [11:0]  colour_s;

  // Latch position/orientation/target flag once per frame so shapes never tear.
  always_comb begin
    if (new_frame_in) begin
      x_lat_d    = x_in;
      y_lat_d    = y_in;
      rot_lat_d  = rotate_in;
      next_lat_d = next_in;
    end else begin
      x_lat_d    = x_lat_q;
      y_lat_d    = y_lat_q;
      rot_lat_d  = rot_lat_q;
      next_lat_d = next_lat_q;
    end
  end

  // Stage 1: signed offsets from the latched box corner, widened by one bit so no wrap.
  always_comb begin
    dx_d     = {1'b0, hcount_in} - {1'b0, x_lat_q};
    dy_d     = {2'b00, vcount_in} - {2'b00, y_lat_q};
    rot_s1_d = rot_lat_q;
  end

  arrow_shape_lut #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .HEAD_H  (HEAD_H),
    .SHAFT_W (SHAFT_W)
  ) u_shape (
    .rot_in    (rot_s1_q),
    .dx_in     (dx_q),
    .dy_in     (dy_q),
    .inbox_out (inbox_s),
    .shape_out (shape_s)
  );

  // Animation FSM: rearm overrides everything; hits only count while shown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (rearm_in) begin
      state_d = S_SHOW;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_SHOW: begin
          if (hit_in) begin
            state_d = S_FLASH;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = S_SHOW;
          end
        end
        S_FLASH: begin
          if (new_frame_in) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = S_FLASH;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_SHOW;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
    flashing_d = (state_d == S_FLASH);
  end

`ifdef ARROW_BLINK_EN
  logic [4:0] blink_q, blink_d;

  // Blink frame counter: restarts whenever the arrow returns to SHOW.
  always_comb begin
    if ((state_q != S_SHOW) && (state_d == S_SHOW)) begin
      blink_d = 5'd0;
    end else if (new_frame_in && (state_q == S_SHOW)) begin
      blink_d = blink_q + 5'd1;
    end else begin
      blink_d = blink_q;
    end
  end

  // Blink counter register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      blink_q <= 5'd0;
    end else begin
      blink_q <= blink_d;
    end
  end

  // Target arrows in SHOW are hidden during the upper half of the blink period.
  always_comb begin
    blink_vis_s = !((state_q == S_SHOW) && next_lat_q && blink_q[4]);
  end
`else
  // No blinking: visibility depends only on shape and state.
  always_comb begin
    blink_vis_s = 1'b1;
  end
`endif

  // Stage 2: final visibility and colour selection.
  always_comb begin
    if (state_q == S_FLASH) begin
      colour_s = HIT_COLOR;
    end else if (next_lat_q) begin
      colour_s = TARGET_COLOR;
    end else begin
      colour_s = NONTARGET_COLOR;
    end
    in_sprite_d = inbox_s & shape_s & (state_q != S_DONE) & blink_vis_s;
    if (in_sprite_d) begin
      pixel_d = colour_s;
    end else begin
      pixel_d = 12'h000;
    end
  end

  // All state and pipeline registers, synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      x_lat_q     <= 11'd0;
      y_lat_q     <= 10'd0;
      rot_lat_q   <= 2'd0;
      next_lat_q  <= 1'b0;
      dx_q        <= 12'd0;
      dy_q        <= 12'd0;
      rot_s1_q    <= 2'd0;
      in_sprite_q <= 1'b0;
      pixel_q     <= 12'h000;
      flashing_q  <= 1'b0;
      done_q      <= 1'b0;
      state_q     <= S_SHOW;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      x_lat_q     <= x_lat_d;
      y_lat_q     <= y_lat_d;
      rot_lat_q   <= rot_lat_d;
      next_lat_q  <= next_lat_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      rot_s1_q    <= rot_s1_d;
      in_sprite_q <= in_sprite_d;
      pixel_q     <= pixel_d;
      flashing_q  <= flashing_d;
      done_q      <= done_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pixel_out    = pixel_q;
  assign in_sprite    = in_sprite_q;
  assign flashing_out = flashing_q;
  assign done_out     = done_q;

endmodule

// File: tb/tb_arrow_sprite_pipe.sv
// Scoreboard bench for arrow_sprite_pipe: pixel requests push expected results,
// a negedge monitor pops them two clocks later; FSM flags are checked inline.
module tb_arrow_sprite_pipe;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = 11'd0;
  logic [9:0]  vcount_in = 10'd0;
  logic [10:0] x_in = 11'd0;
  logic [9:0]  y_in = 10'd0;
  logic [1:0]  rotate_in = 2'd0;
  logic        next_in = 1'b0;
  logic        new_frame_in = 1'b0;
  logic        hit_in = 1'b0;
  logic        rearm_in = 1'b0;
  logic [11:0] pixel_out;
  logic        in_sprite;
  logic        flashing_out;
  logic        done_out;

  arrow_sprite_pipe dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .x_in         (x_in),
    .y_in         (y_in),
    .rotate_in    (rotate_in),
    .next_in      (next_in),
    .new_frame_in (new_frame_in),
    .hit_in       (hit_in),
    .rearm_in     (rearm_in),
    .pixel_out    (pixel_out),
    .in_sprite    (in_sprite),
    .flashing_out (flashing_out),
    .done_out     (done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        ins;
    logic [11:0] pix;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  req = 1'b0;
  logic [1:0] vpipe = 2'b00;
  int    n_vec = 0;
  int    n_miss = 0;

  // Bench-side model of the two-clock render latency.
  always @(posedge clk_in) begin
    vpipe <= {vpipe[0], req};
  end

  // Monitor: compare the DUT output with the oldest expected entry.
  always @(negedge clk_in) begin
    exp_t  e;
    string nm;
    if (vpipe[1]) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL scoreboard_empty: output presented with no expected entry");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ((in_sprite !== e.ins) || (pixel_out !== e.pix)) begin
          n_miss++;
          $display("FAIL %s: got in_sprite=%0b pixel=%h, want in_sprite=%0b pixel=%h",
                   nm, in_sprite, pixel_out, e.ins, e.pix);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_px(input int h, input int v, input logic ins,
                          input logic [11:0] pix, input string nm);
    exp_t e;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    e.ins = ins;
    e.pix = pix;
    exp_q.push_back(e);
    name_q.push_back(nm);
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  task automatic chk1(input string nm, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0b want %0b", nm, got, want);
    end
  endtask

  task automatic chk12(input string nm, input logic [11:0] got, input logic [11:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic latch(input int x, input int y, input int rot, input logic nxt);
    x_in = 11'(x);
    y_in = 10'(y);
    rotate_in = 2'(rot);
    next_in = nxt;
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
  endtask

  task automatic frame();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
  endtask

  task automatic hit();
    hit_in = 1'b1;
    tick();
    hit_in = 1'b0;
  endtask

  task automatic rearm();
    rearm_in = 1'b1;
    tick();
    rearm_in = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_in = 1'b0;
    repeat (3) tick();
    chk1("rst_in_sprite", in_sprite, 1'b0);
    chk12("rst_pixel", pixel_out, 12'h000);
    chk1("rst_flashing", flashing_out, 1'b0);
    chk1("rst_done", done_out, 1'b0);
    rst_in = 1'b1;
    tick();

    // Tip up at (100,50), target colour
    latch(100, 50, 0, 1'b1);
    drive_px(107, 50, 1'b1, 12'hF00, "rot0_tip");
    drive_px(100, 50, 1'b0, 12'h000, "rot0_tip_row_edge");
    drive_px(104, 70, 1'b1, 12'hF00, "rot0_shaft_left");
    drive_px(103, 70, 1'b0, 12'h000, "rot0_shaft_outside");
    drive_px(100, 57, 1'b1, 12'hF00, "rot0_head_base");
    drive_px(108, 81, 1'b1, 12'hF00, "rot0_tail_row");
    drive_px(108, 82, 1'b0, 12'h000, "rot0_below_box");
    drain();

    // Tip right: box 32 wide x 16 tall
    latch(100, 50, 1, 1'b1);
    drive_px(131, 57, 1'b1, 12'hF00, "rot1_tip");
    drive_px(120, 52, 1'b0, 12'h000, "rot1_off_shaft");
    drive_px(131, 66, 1'b0, 12'h000, "rot1_below_box");
    drive_px(100, 54, 1'b1, 12'hF00, "rot1_tail");

    // Mid-frame input change must not move the sprite
    x_in = 11'd200;
    drive_px(131, 57, 1'b1, 12'hF00, "midframe_unchanged");
    drain();
    latch(200, 50, 1, 1'b0);
    drive_px(231, 57, 1'b1, 12'hFF0, "relatched_new_pos");
    drive_px(131, 57, 1'b0, 12'h000, "relatched_old_pos");
    drain();

    // No wrap at the left edge
    latch(0, 50, 0, 1'b1);
    drive_px(2047, 50, 1'b0, 12'h000, "no_wrap_h2047");
    drive_px(7, 50, 1'b1, 12'hF00, "x0_tip");
    drive_px(7, 10, 1'b0, 12'h000, "negative_dy");
    drain();

    // Hit, flash for 8 frames, retire, rearm
    latch(100, 50, 0, 1'b1);
    hit();
    chk1("flash_entered", flashing_out, 1'b1);
    drive_px(107, 50, 1'b1, 12'hFFF, "flash_colour");
    drain();
    for (int k = 1; k <= 8; k++) begin
      frame();
      chk1("done_pulse", done_out, (k == 8));
    end
    chk1("flash_left", flashing_out, 1'b0);
    tick();
    chk1("done_one_cycle", done_out, 1'b0);
    drive_px(107, 50, 1'b0, 12'h000, "done_invisible");
    drain();
    rearm();
    chk1("rearm_not_flashing", flashing_out, 1'b0);
    drive_px(107, 50, 1'b1, 12'hF00, "rearm_colour");
    drain();

    // hit_in during FLASH is ignored: done still after 8 frames total
    hit();
    for (int k = 1; k <= 4; k++) begin
      frame();
      chk1("done_early_a", done_out, 1'b0);
    end
    hit();
    for (int k = 5; k <= 8; k++) begin
      frame();
      chk1("done_after_rehit", done_out, (k == 8));
    end
    rearm();

    // Same-cycle hit + rearm in SHOW stays in SHOW
    hit_in = 1'b1;
    rearm_in = 1'b1;
    tick();
    hit_in = 1'b0;
    rearm_in = 1'b0;
    chk1("hit_rearm_same_cycle", flashing_out, 1'b0);
    drive_px(107, 50, 1'b1, 12'hF00, "hit_rearm_colour");
    drain();

    // rearm mid-FLASH returns to SHOW
    hit();
    repeat (3) frame();
    rearm();
    chk1("rearm_mid_flash", flashing_out, 1'b0);
    drive_px(107, 50, 1'b1, 12'hF00, "rearm_mid_flash_colour");
    drain();

    // Reset mid-FLASH clears everything on the next edge
    hit();
    chk1("flash_before_reset", flashing_out, 1'b1);
    drive_px(107, 50, 1'b1, 12'hFFF, "flash_before_reset_px");
    drain();
    rst_in = 1'b0;
    tick();
    chk1("reset_flashing", flashing_out, 1'b0);
    chk1("reset_in_sprite", in_sprite, 1'b0);
    chk12("reset_pixel", pixel_out, 12'h000);
    chk1("reset_done", done_out, 1'b0);
    rst_in = 1'b1;
    tick();
    // Latched values are back at 0/0/up/non-target
    drive_px(7, 0, 1'b1, 12'hFF0, "post_reset_latch");
    drain();

    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_leftover: %0d entries never compared, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
